ifu: RTL
========

# ifu

Instruction fetch unit for the single-cycle NPC core. It owns the architectural PC and issues word fetches to instruction memory over a valid/ready request channel, taking one response per request. It buffers the returned instruction for the decode/execute datapath, which takes it over a valid/ready handshake. It accepts PC redirects from the execute stage, and responses to superseded fetches are dropped.

## Interface
- XLEN, 32: address/data width.
- RESET_PC, 32'h8000_0000: PC loaded on reset.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  XLEN  fetch address (word aligned).
- imem_resp_valid_i  in  1  response valid (one per accepted request, ≥1 cycle after acceptance).
- imem_resp_data_i  in  32  fetched instruction.
- instr_valid_o  out  1  instruction buffer holds a valid instruction.
- instr_ready_i  in  1  consumer takes instruction.
- instr_o  out  32  buffered instruction.
- instr_pc_o  out  XLEN  PC of instr_o.
- redirect_valid_i  in  1  load new PC (jump/branch taken).
- redirect_pc_i  in  XLEN  target; bits [1:0] ignored (forced 0).

## Operation
- Registers: pc_r, inflight_pc_r, drop_r, instr_r, instr_pc_r, 2-bit state. All are reset by rst_i.
- States: IDLE, REQ, WAIT, HOLD.
- Outputs: imem_req_valid_o = (state==REQ). imem_req_addr_o = pc_r. instr_valid_o = (state==HOLD).
- IDLE: entered on reset. Responses are ignored. Moves to REQ after one cycle.
- REQ, on request handshake (valid && ready):
  - inflight_pc_r <= pc_r.
  - pc_r <= pc_r + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - Go to WAIT with drop_r <= 0.
- WAIT, on imem_resp_valid_i:
  - If drop_r: discard the response and go to REQ.
  - Otherwise: instr_r <= data, instr_pc_r <= inflight_pc_r, go to HOLD.
- HOLD, on instr_valid_o && instr_ready_i: go to REQ.
- Redirect priority: redirect_valid_i overrides the sequential PC. pc_r <= {redirect_pc_i[XLEN-1:2],2'b00} in every state except IDLE, where it is ignored.
  - REQ + redirect + handshake: the request issues with the old PC, then WAIT with drop_r <= 1.
  - REQ + redirect, no handshake: stay in REQ. The next cycle requests the new PC.
  - WAIT + redirect: drop_r <= 1 and stay in WAIT. If a response arrives in the same cycle, it is discarded and the state goes to REQ.
  - HOLD + redirect: the buffer is invalidated and the state goes to REQ. If instr_ready_i is high in the same cycle, that handshake still counts as consumed.
- Only one request is outstanding at any time. No new request issues until the response is received or dropped.
- Responses in IDLE, REQ or HOLD are protocol violations and are ignored.

## Timing
- Reset values:
  - imem_req_valid_o=0, instr_valid_o=0.
  - imem_req_addr_o=RESET_PC.
  - instr_o=0, instr_pc_o=0.
- First request: imem_req_valid_o rises in the 2nd cycle after rst_i deasserts (IDLE lasts 1 cycle).
- Best-case sequence with ready=1 and 1-cycle response:
  - REQ (cycle n), WAIT (n+1, response), HOLD (n+2), REQ (n+3).
  - Throughput is 1 instruction per 3 cycles.
- instr_valid_o stays high and instr_o/instr_pc_o stay stable until the handshake or a redirect.
- Redirect-to-request latency: new address on imem_req_addr_o the cycle after redirect, provided the unit is in REQ then.
- Asynchronous reset mid-WAIT: state goes to IDLE immediately. A late response to the pre-reset request that arrives while in IDLE is ignored.

## Test plan
- Reset/sequential fetch:
  - Setup: release reset; memory always ready; 1-cycle latency returns 32'h00000013 for each address.
  - Required: requests at 8000_0000, 8000_0004, 8000_0008; instr_pc_o matches each request.
  - Required: imem_req_valid_o=0 during reset and in the first cycle after.
- Backpressure:
  - Setup: hold instr_ready_i=0 for 5 cycles in HOLD.
  - Required: instr_o/instr_pc_o stable; no new request.
  - Required: after ready=1, the next request is at PC+4.
- Redirect in WAIT:
  - Setup: redirect_pc_i=32'h8000_0100 while a fetch of 8000_0004 is outstanding.
  - Required: the response is discarded with instr_valid_o kept 0; next request at 8000_0100.
  - Required: redirect_pc_i=32'h8000_0103 fetches 8000_0100.
- Redirect with simultaneous handshake:
  - Setup: in REQ, redirect to 8000_0200 while ready=1.
  - Required: the old request issues and its response is dropped; next request at 8000_0200.
- Wrap-around:
  - Setup: redirect to FFFF_FFFC.
  - Required: the following request is at 0000_0000.
- Reset mid-operation:
  - Setup: assert rst_i in WAIT; deliver the response during reset/IDLE.
  - Required: no instr_valid_o; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the architectural PC, keeps at most one word
// fetch in flight and buffers the returned instruction for the datapath.
module ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [1:0]      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. The instruction buffer holds valid and payload stable until it
  // is taken or a redirect invalidates it; a redirect may retarget a request
  // that has not yet been accepted.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_r, state_d;
  logic [XLEN-1:0]   pc_r, pc_d;
  logic [XLEN-1:0]   inflight_pc_r, inflight_pc_d;
  logic              drop_r, drop_d;
  logic [31:0]       instr_r, instr_d;
  logic [XLEN-1:0]   instr_pc_r, instr_pc_d;

  logic              req_fire;
  logic              instr_fire;
  logic [XLEN-1:0]   redirect_target;

  assign imem_req_valid_o = (state_r == REQ);
  assign imem_req_addr_o  = pc_r;
  assign instr_valid_o    = (state_r == HOLD);
  assign instr_o          = instr_r;
  assign instr_pc_o       = instr_pc_r;
  assign state_dbg        = state_r;

  assign req_fire        = imem_req_valid_o && imem_req_ready_i;
  assign instr_fire      = instr_valid_o && instr_ready_i;
  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      inflight_pc_r <= '0;
      drop_r        <= 1'b0;
      instr_r       <= '0;
      instr_pc_r    <= '0;
    end else begin
      state_r       <= state_d;
      pc_r          <= pc_d;
      inflight_pc_r <= inflight_pc_d;
      drop_r        <= drop_d;
      instr_r       <= instr_d;
      instr_pc_r    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_r;
    pc_d          = pc_r;
    inflight_pc_d = inflight_pc_r;
    drop_d        = drop_r;
    instr_d       = instr_r;
    instr_pc_d    = instr_pc_r;

    case (state_r)
      // Redirects and stray responses are ignored while leaving reset.
      IDLE: state_d = REQ;

      REQ: begin
        if (req_fire) begin
          inflight_pc_d = pc_r;
          pc_d          = pc_r + XLEN'(4);
          drop_d        = redirect_valid_i;
          state_d       = WAIT;
        end
        if (redirect_valid_i) begin
          pc_d = redirect_target;
        end
      end

      WAIT: begin
        if (imem_resp_valid_i) begin
          // A redirect seen in the response cycle makes this fetch stale too.
          if (drop_r || redirect_valid_i) begin
            state_d = REQ;
          end else begin
            instr_d    = imem_resp_data_i;
            instr_pc_d = inflight_pc_r;
            state_d    = HOLD;
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
        if (redirect_valid_i) begin
          pc_d = redirect_target;
        end
      end

      HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (instr_fire) begin
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
